projection_frame_sequencer: RTL and testbench

//  Per-frame sequencer for the 3D->2D triangle projection pipeline.
//  - On each frame_start, snapshots the camera pose.
//  - Issues exactly SIZE triangle-fetch strobes to the projector, honouring rasterizer back-pressure.
//  - Counts the projected triangles that return.
//  - Signals frame completion.
//  - Keeps the projector's free-running model address aligned to triangle 0 at every frame start.

---
 rtl/proj_pkg.sv | 33 +++
 rtl/projection_frame_sequencer.sv | 145 ++++++++++++++
 tb/tb_projection_frame_sequencer.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/proj_pkg.sv
// Shared types and helpers for the triangle projection pipeline.
//   seq_state_t : frame sequencer states
//   CAM_W       : packed camera pose width {theta[8:0], x[6:0], y[6:0], z[6:0]}
//   THETA_W     : theta field width (degrees)
//   THETA_FULL  : one full turn in degrees
//   wrap_theta  : folds theta >= 360 back into 0..359; x/y/z pass through
package proj_pkg;

  localparam int unsigned CAM_W      = 30;
  localparam int unsigned THETA_W    = 9;
  localparam int unsigned THETA_FULL = 360;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    ISSUE,
    DRAIN,
    DONE
  } seq_state_t;

  // A 9-bit theta tops out at 511, so a single subtraction of 360 is enough.
  function automatic logic [CAM_W-1:0] wrap_theta(input logic [CAM_W-1:0] cam);
    logic [THETA_W-1:0] theta;
    logic [CAM_W-1:0]   res;
    theta = cam[CAM_W-1 -: THETA_W];
    res   = cam;
    if (theta >= THETA_W'(THETA_FULL)) begin
      res[CAM_W-1 -: THETA_W] = theta - THETA_W'(THETA_FULL);
    end
    return res;
  endfunction

endpackage

// File: rtl/projection_frame_sequencer.sv
// Per-frame sequencer for the 3D->2D triangle projection pipeline.
// Snapshots the camera pose at frame start, issues SIZE triangle strobes to
// the projector (stalling on rasterizer back-pressure), counts returning
// projected triangles and pulses frame_done once all have come back. Because
// the projector walks its model addresses in lockstep with the strobes, issuing
// exactly SIZE strobes per frame keeps it aligned to triangle 0.
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   enable           accept new frame_start pulses
//   frame_start      1-cycle frame request
//   camera_loc_in    {theta, x, y, z} camera pose
//   raster_busy      rasterizer back-pressure
//   proj_valid_out   projector result strobe
//   proj_valid_in    triangle strobe to projector
//   proj_camera_loc  latched (theta-wrapped) camera pose
//   frame_done       1-cycle pulse at frame completion
//   busy             sequencer not idle
//   overrun          sticky: frame request lost (queue already full)
//   wd_error         sticky: drain watchdog expired
module projection_frame_sequencer
  import proj_pkg::*;
#(
  parameter int unsigned SIZE      = 4,
  parameter int unsigned LATENCY   = 8,
  parameter int unsigned WD_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             frame_start,
  input  logic [CAM_W-1:0] camera_loc_in,
  input  logic             raster_busy,
  input  logic             proj_valid_out,
  output logic             proj_valid_in,
  output logic [CAM_W-1:0] proj_camera_loc,
  output logic             frame_done,
  output logic             busy,
  output logic             overrun,
  output logic             wd_error
);

  localparam int unsigned CNT_W = $clog2(SIZE + 1);
  localparam int unsigned WD_W  = $clog2(WD_CYCLES + 1);

  localparam logic [CNT_W-1:0] LAST_ISSUE = CNT_W'(SIZE - 1);
  localparam logic [CNT_W-1:0] ALL_RET    = CNT_W'(SIZE);
  localparam logic [WD_W-1:0]  WD_LAST    = WD_W'(WD_CYCLES - 1);

  if (SIZE < 1 || LATENCY < 1 || WD_CYCLES < 1) begin : g_bad_params
    $error("projection_frame_sequencer: SIZE, LATENCY and WD_CYCLES must be >= 1");
  end

  seq_state_t       state, state_n;
  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] ret_cnt, ret_cnt_n;
  logic [WD_W-1:0]  wd_cnt;
  logic             pending;

  logic start_req;
  logic ret_hit;
  logic ret_all;
  logic wd_expire;

  always_comb begin
    state_n       = state;
    proj_valid_in = 1'b0;
    frame_done    = 1'b0;
    busy          = (state != IDLE);
    start_req     = frame_start & enable;

    // Returns count in ISSUE and DRAIN only, and saturate at SIZE.
    ret_hit   = proj_valid_out && (state == ISSUE || state == DRAIN) && (ret_cnt != ALL_RET);
    ret_cnt_n = ret_cnt + CNT_W'(ret_hit);
    ret_all   = (ret_cnt_n == ALL_RET);
    wd_expire = (state == DRAIN) && !raster_busy && (wd_cnt == WD_LAST);

    case (state)
      IDLE: begin
        if (start_req) state_n = LATCH;
      end
      LATCH: begin
        state_n = ISSUE;
      end
      ISSUE: begin
        proj_valid_in = ~raster_busy;
        if (proj_valid_in && issue_cnt == LAST_ISSUE) state_n = DRAIN;
      end
      DRAIN: begin
        if (ret_all || wd_expire) state_n = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        // A request landing on DONE itself is taken straight away.
        state_n = (pending || start_req) ? LATCH : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      issue_cnt       <= '0;
      ret_cnt         <= '0;
      wd_cnt          <= '0;
      pending         <= 1'b0;
      overrun         <= 1'b0;
      wd_error        <= 1'b0;
      proj_camera_loc <= '0;
    end else begin
      state <= state_n;

      case (state)
        LATCH: begin
          proj_camera_loc <= wrap_theta(camera_loc_in);
          issue_cnt       <= '0;
          ret_cnt         <= '0;
          wd_cnt          <= '0;
        end
        ISSUE: begin
          if (proj_valid_in) issue_cnt <= issue_cnt + CNT_W'(1);
          ret_cnt <= ret_cnt_n;
        end
        DRAIN: begin
          ret_cnt <= ret_cnt_n;
          if (!raster_busy) wd_cnt <= wd_cnt + WD_W'(1);
          // A frame that completes on the expiry cycle is not a timeout.
          if (wd_expire && !ret_all) wd_error <= 1'b1;
        end
        default: ;
      endcase

      // One-deep frame queue. DONE consumes the queued request; a second
      // request while one is already queued is dropped and flagged.
      if (state == DONE) begin
        pending <= 1'b0;
        if (start_req && pending) overrun <= 1'b1;
      end else if (state != IDLE && start_req) begin
        if (pending) overrun <= 1'b1;
        else         pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_projection_frame_sequencer.sv
module tb_projection_frame_sequencer;

  localparam int SIZE = 4;
  localparam int LAT  = 8;
  localparam int WD   = 16;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        frame_start;
  logic [29:0] camera_loc_in;
  logic        raster_busy;
  logic        proj_valid_out;
  logic        proj_valid_in;
  logic [29:0] proj_camera_loc;
  logic        frame_done;
  logic        busy;
  logic        overrun;
  logic        wd_error;

  projection_frame_sequencer #(
    .SIZE     (SIZE),
    .LATENCY  (LAT),
    .WD_CYCLES(WD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .frame_start    (frame_start),
    .camera_loc_in  (camera_loc_in),
    .raster_busy    (raster_busy),
    .proj_valid_out (proj_valid_out),
    .proj_valid_in  (proj_valid_in),
    .proj_camera_loc(proj_camera_loc),
    .frame_done     (frame_done),
    .busy           (busy),
    .overrun        (overrun),
    .wd_error       (wd_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt = 0;
  int ret_budget = 1000;
  int bz_from = -1;
  int bz_to   = -1;

  int          exp_strobe[$];
  int          exp_done[$];
  logic [29:0] exp_cam[$];
  int          pq[$];

  function automatic logic [29:0] cam(input int th, input int x, input int y, input int z);
    return {9'(th), 7'(x), 7'(y), 7'(z)};
  endfunction

  // One clock cycle: apply back-pressure, sample/score outputs mid-cycle,
  // cross the edge, then present this cycle's projector return.
  task automatic step();
    int e;
    logic [29:0] ec;
    raster_busy = (cyc >= bz_from && cyc <= bz_to);
    #2;
    if (proj_valid_in === 1'b1) begin
      total++;
      if (exp_strobe.size() == 0) begin
        bad++;
        $display("FAIL strobe_extra cyc=%0d got=strobe required=none", cyc);
      end else begin
        e = exp_strobe.pop_front();
        if (cyc !== e) begin
          bad++;
          $display("FAIL strobe_cycle got=%0d required=%0d", cyc, e);
        end
      end
      total++;
      if (raster_busy !== 1'b0) begin
        bad++;
        $display("FAIL strobe_under_busy cyc=%0d got raster_busy=%b required=0", cyc, raster_busy);
      end
      pq.push_back(cyc + LAT);
    end
    if (frame_done === 1'b1) begin
      done_cnt++;
      total++;
      if (exp_done.size() == 0) begin
        bad++;
        $display("FAIL done_extra cyc=%0d got=frame_done required=none", cyc);
      end else begin
        e = exp_done.pop_front();
        if (cyc !== e) begin
          bad++;
          $display("FAIL done_cycle got=%0d required=%0d", cyc, e);
        end
      end
      total++;
      if (exp_cam.size() == 0) begin
        bad++;
        $display("FAIL cam_extra cyc=%0d got=%h required=none", cyc, proj_camera_loc);
      end else begin
        ec = exp_cam.pop_front();
        if (proj_camera_loc !== ec) begin
          bad++;
          $display("FAIL cam_at_done got=%h required=%h", proj_camera_loc, ec);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    frame_start    = 1'b0;
    proj_valid_out = 1'b0;
    if (pq.size() > 0 && pq[0] == cyc) begin
      void'(pq.pop_front());
      if (ret_budget > 0) begin
        proj_valid_out = 1'b1;
        ret_budget--;
      end
    end
  endtask

  task automatic run_until_done(input int target, input int limit, input string name);
    for (int i = 0; i < limit && done_cnt < target; i++) step();
    total++;
    if (done_cnt < target) begin
      bad++;
      $display("FAIL %s_timeout got done_cnt=%0d required=%0d", name, done_cnt, target);
    end
  endtask

  task automatic one_frame(input logic [29:0] cin, input logic [29:0] cexp, input string name);
    int t;
    int target;
    camera_loc_in = cin;
    t = cyc;
    for (int k = 0; k < SIZE; k++) exp_strobe.push_back(t + 2 + k);
    exp_done.push_back(t + 14);
    exp_cam.push_back(cexp);
    frame_start = 1'b1;
    target = done_cnt + 1;
    step();
    run_until_done(target, 40, name);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_busy_after_done got=%b required=0", name, busy);
    end
    for (int k = 0; k < 3; k++) step();
    total++;
    if (done_cnt !== target) begin
      bad++;
      $display("FAIL %s_done_once got=%0d required=%0d", name, done_cnt, target);
    end
    total++;
    if (exp_strobe.size() != 0) begin
      bad++;
      $display("FAIL %s_strobes_missing got=%0d left required=0", name, exp_strobe.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++;
    if ({proj_valid_in, frame_done, busy, overrun, wd_error} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b required=00000",
               {proj_valid_in, frame_done, busy, overrun, wd_error});
    end
    total++;
    if (proj_camera_loc !== 30'd0) begin
      bad++;
      $display("FAIL reset_cam got=%h required=0", proj_camera_loc);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    enable = 1'b0;
    frame_start = 1'b1;
    for (int k = 0; k < 5; k++) step();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL disabled_start got busy=%b required=0", busy);
    end
    enable = 1'b1;
    one_frame(cam(359, 3, 4, 5), cam(359, 3, 4, 5), "basic");
  endtask

  task automatic test_backpressure();
    int t;
    int target;
    camera_loc_in = cam(90, 9, 8, 7);
    t = cyc;
    bz_from = t + 3;
    bz_to   = t + 4;
    exp_strobe.push_back(t + 2);
    exp_strobe.push_back(t + 5);
    exp_strobe.push_back(t + 6);
    exp_strobe.push_back(t + 7);
    exp_done.push_back(t + 16);
    exp_cam.push_back(cam(90, 9, 8, 7));
    frame_start = 1'b1;
    target = done_cnt + 1;
    step();
    run_until_done(target, 40, "bp");
    bz_from = -1;
    bz_to   = -1;
    step();
    total++;
    if (exp_strobe.size() != 0) begin
      bad++;
      $display("FAIL bp_strobes_missing got=%0d left required=0", exp_strobe.size());
    end
  endtask

  task automatic test_camera();
    int t;
    int target;
    logic [29:0] ce;
    ce = cam(10, 5, 1, 2);
    camera_loc_in = cam(370, 5, 1, 2);
    t = cyc;
    for (int k = 0; k < SIZE; k++) exp_strobe.push_back(t + 2 + k);
    exp_done.push_back(t + 14);
    exp_cam.push_back(ce);
    frame_start = 1'b1;
    target = done_cnt + 1;
    step();
    step();
    total++;
    if (proj_camera_loc !== ce) begin
      bad++;
      $display("FAIL cam_wrap got=%h required=%h", proj_camera_loc, ce);
    end
    camera_loc_in = cam(100, 20, 20, 20);
    for (int i = 0; i < 30 && done_cnt < target; i++) begin
      step();
      total++;
      if (proj_camera_loc !== ce) begin
        bad++;
        $display("FAIL cam_stable cyc=%0d got=%h required=%h", cyc, proj_camera_loc, ce);
      end
    end
    total++;
    if (done_cnt < target) begin
      bad++;
      $display("FAIL cam_timeout got done_cnt=%0d required=%0d", done_cnt, target);
    end
    step();
  endtask

  task automatic test_queue();
    int t;
    int d0;
    t  = cyc;
    d0 = done_cnt;
    for (int k = 0; k < SIZE; k++) exp_strobe.push_back(t + 2 + k);
    for (int k = 0; k < SIZE; k++) exp_strobe.push_back(t + 16 + k);
    exp_done.push_back(t + 14);
    exp_done.push_back(t + 28);
    exp_cam.push_back(cam(45, 1, 1, 1));
    exp_cam.push_back(cam(0, 2, 2, 2));
    camera_loc_in = cam(45, 1, 1, 1);
    for (int i = 0; i < 30; i++) begin
      if (i == 0 || i == 3 || i == 5) frame_start = 1'b1;
      if (i == 3) camera_loc_in = cam(360, 2, 2, 2);
      if (i == 15) begin
        total++;
        if (busy !== 1'b1) begin
          bad++;
          $display("FAIL queue_no_idle got busy=%b required=1", busy);
        end
      end
      step();
      if (i == 3) begin
        total++;
        if (overrun !== 1'b0) begin
          bad++;
          $display("FAIL queue_pending_not_overrun got=%b required=0", overrun);
        end
      end
      if (i == 5) begin
        total++;
        if (overrun !== 1'b1) begin
          bad++;
          $display("FAIL queue_overrun got=%b required=1", overrun);
        end
      end
    end
    total++;
    if (done_cnt !== d0 + 2) begin
      bad++;
      $display("FAIL queue_done_count got=%0d required=%0d", done_cnt, d0 + 2);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL queue_idle_after got busy=%b required=0", busy);
    end
  endtask

  task automatic test_watchdog();
    int t;
    t = cyc;
    ret_budget = 3;
    camera_loc_in = cam(200, 6, 6, 6);
    for (int k = 0; k < SIZE; k++) exp_strobe.push_back(t + 2 + k);
    exp_done.push_back(t + 22);
    exp_cam.push_back(cam(200, 6, 6, 6));
    frame_start = 1'b1;
    for (int i = 0; i < 23; i++) begin
      if (i == 21) begin
        total++;
        if (wd_error !== 1'b0) begin
          bad++;
          $display("FAIL wd_early got=%b required=0", wd_error);
        end
      end
      if (i == 22) begin
        total++;
        if (wd_error !== 1'b1) begin
          bad++;
          $display("FAIL wd_set got=%b required=1", wd_error);
        end
      end
      step();
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL wd_idle got busy=%b required=0", busy);
    end
    step();
    total++;
    if (wd_error !== 1'b1) begin
      bad++;
      $display("FAIL wd_sticky got=%b required=1", wd_error);
    end
    ret_budget = 1000;
  endtask

  task automatic test_reset_mid();
    int t;
    t = cyc;
    camera_loc_in = cam(300, 1, 2, 3);
    exp_strobe.push_back(t + 2);
    exp_strobe.push_back(t + 3);
    frame_start = 1'b1;
    for (int i = 0; i < 3; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    pq.delete();
    proj_valid_out = 1'b0;
    total++;
    if ({proj_valid_in, frame_done, busy, overrun, wd_error} !== 5'b0) begin
      bad++;
      $display("FAIL midreset_flags got=%b required=00000",
               {proj_valid_in, frame_done, busy, overrun, wd_error});
    end
    total++;
    if (proj_camera_loc !== 30'd0) begin
      bad++;
      $display("FAIL midreset_cam got=%h required=0", proj_camera_loc);
    end
    total++;
    if (exp_strobe.size() != 0) begin
      bad++;
      $display("FAIL midreset_strobes got=%0d left required=0", exp_strobe.size());
    end
    step();
    one_frame(cam(511, 7, 7, 7), cam(151, 7, 7, 7), "post_reset");
  endtask

  initial begin
    rst            = 1'b1;
    enable         = 1'b1;
    frame_start    = 1'b0;
    camera_loc_in  = '0;
    raster_busy    = 1'b0;
    proj_valid_out = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_camera();
    test_queue();
    test_watchdog();
    test_reset_mid();
    total++;
    if (exp_done.size() != 0) begin
      bad++;
      $display("FAIL done_missing got=%0d left required=0", exp_done.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
